// File: rtl/seg_mux_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seg_mux_decoder
// Watches the multiplexed 7-segment bus (anodes + segments, both active-low)
// driven by the timer display scan, rebuilds the four displayed BCD digits
// (MM:SS) and publishes them as one coherent frame once all four positions
// have been seen in scan order.
//
// Ports
//   clk          in   1   system clock (clk_5MHz domain)
//   reset        in   1   asynchronous, active-high reset
//   an           in   8   anode enables, active-low; an[3:0] select digit 0..3
//   seg          in   8   segments, active-low {dp,g,f,e,d,c,b,a}; dp ignored
//   time_bcd     out  16  {digit0,digit1,digit2,digit3} = {M_TENS,M_ONES,S_TENS,S_ONES}
//   frame_valid  out  1   one-clock pulse: time_bcd refreshed with a full frame
//   seq_err      out  1   one-clock pulse: digit position captured out of order
//   dec_err      out  1   one-clock pulse: captured glyph is not a digit 0-9
//   stale        out  1   level: no capture for TIMEOUT_CYCLES clocks
//
// SETTLE_CYCLES must be at least 2.
// -----------------------------------------------------------------------------
module seg_mux_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] time_bcd,
  output logic        frame_valid,
  output logic        seq_err,
  output logic        dec_err,
  output logic        stale
);

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] CAPTURE_AT = SW'(SETTLE_CYCLES - 2);
  localparam logic [16:0]   TO_MAX     = 17'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {SYNC, COLLECT, PUBLISH} state_t;

  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic [14:0]   r_prev_key;
  logic [SW-1:0] r_settle;
  logic [16:0]   r_to;
  logic          r_stale;
  state_t        r_state;
  logic [1:0]    r_expect;
  logic [3:0]    r_shadow [4];
  logic [15:0]   r_time;
  logic          r_frame_valid;
  logic          r_seq_err;
  logic          r_dec_err;

  logic [14:0]   w_key;
  logic          w_same;
  logic          w_valid;
  logic          w_capture;
  logic [1:0]    w_pos;
  logic [3:0]    w_digit;
  logic          w_bad;
  logic [16:0]   w_to_next;
  logic          w_stale_set;
  logic          w_unused;

  // The decimal point is dropped at the input stage so it can never reach
  // the settle comparison or the decoder.
  assign w_unused = seg[7];

  // NOTE: clocked state is written with <= so every register samples the
  // values from before the edge; = here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 8'h00;
      r_seg <= 7'h00;
    end else begin
      r_an  <= an;
      r_seg <= seg[6:0];
    end
  end

  assign w_key   = {r_an, r_seg};
  assign w_same  = (w_key == r_prev_key);
  // Only the low nibble drives digits; the upper anodes must all be off.
  assign w_valid = (r_an[7:4] == 4'hF) && $onehot(~r_an[3:0]);
  // Fires on the one cycle the settle counter steps onto its saturation value,
  // so a held digit is captured exactly once.
  assign w_capture = w_valid && w_same && (r_settle == CAPTURE_AT);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_pos = 2'd0;
    case (r_an[3:0])
      4'b1110: w_pos = 2'd0;
      4'b1101: w_pos = 2'd1;
      4'b1011: w_pos = 2'd2;
      4'b0111: w_pos = 2'd3;
      default: w_pos = 2'd0;
    endcase
  end

  always_comb begin
    w_digit = 4'hF;
    w_bad   = 1'b0;
    case (r_seg)
      7'h40:   w_digit = 4'd0;
      7'h79:   w_digit = 4'd1;
      7'h24:   w_digit = 4'd2;
      7'h30:   w_digit = 4'd3;
      7'h19:   w_digit = 4'd4;
      7'h12:   w_digit = 4'd5;
      7'h02:   w_digit = 4'd6;
      7'h78:   w_digit = 4'd7;
      7'h00:   w_digit = 4'd8;
      7'h10:   w_digit = 4'd9;
      default: w_bad   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_key <= '0;
      r_settle   <= '0;
    end else begin
      r_prev_key <= w_key;
      if (!w_valid || !w_same) begin
        r_settle <= '0;
      end else if (r_settle != SETTLE_MAX) begin
        r_settle <= r_settle + SW'(1);
      end
    end
  end

  // A capture in the same cycle the counter would saturate wins: the counter
  // clears and stale never rises.
  always_comb begin
    w_to_next = r_to;
    if (w_capture) begin
      w_to_next = 17'd0;
    end else if (r_to != TO_MAX) begin
      w_to_next = r_to + 17'd1;
    end
  end

  assign w_stale_set = !r_stale && (w_to_next == TO_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to    <= 17'd0;
      r_stale <= 1'b0;
    end else begin
      r_to    <= w_to_next;
      r_stale <= (w_to_next == TO_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= SYNC;
      r_expect      <= 2'd0;
      r_time        <= 16'h0000;
      r_frame_valid <= 1'b0;
      r_seq_err     <= 1'b0;
      r_dec_err     <= 1'b0;
      // NOTE: the shadow digits are reset too, so a reset mid-frame can never
      // leak half a frame into a later publish.
      for (int i = 0; i < 4; i++) r_shadow[i] <= 4'h0;
    end else begin
      r_frame_valid <= 1'b0;
      r_seq_err     <= 1'b0;
      r_dec_err     <= w_capture && w_bad;

      case (r_state)
        SYNC: begin
          if (w_capture && (w_pos == 2'd0)) begin
            r_shadow[0] <= w_digit;
            r_expect    <= 2'd1;
            r_state     <= COLLECT;
          end
        end

        COLLECT: begin
          if (w_capture) begin
            if (w_pos == r_expect) begin
              r_shadow[w_pos] <= w_digit;
              if (w_pos == 2'd3) r_state <= PUBLISH;
              else               r_expect <= r_expect + 2'd1;
            end else if (w_pos == (r_expect - 2'd1)) begin
              // Same digit re-settled after a segment change: keep the newest.
              r_shadow[w_pos] <= w_digit;
            end else begin
              r_seq_err <= 1'b1;
              for (int i = 0; i < 4; i++) r_shadow[i] <= 4'h0;
              if (w_pos == 2'd0) begin
                r_shadow[0] <= w_digit;
                r_expect    <= 2'd1;
              end else begin
                r_state <= SYNC;
              end
            end
          end
        end

        PUBLISH: begin
          r_time        <= {r_shadow[0], r_shadow[1], r_shadow[2], r_shadow[3]};
          r_frame_valid <= 1'b1;
          r_state       <= SYNC;
        end

        default: r_state <= SYNC;
      endcase

      // A display that has gone quiet must resynchronise from digit 0.
      if (w_stale_set) r_state <= SYNC;
    end
  end

  assign time_bcd    = r_time;
  assign frame_valid = r_frame_valid;
  assign seq_err     = r_seq_err;
  assign dec_err     = r_dec_err;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seg_mux_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for seg_mux_decoder. Stimulus is a list of "hold this
// an/seg word for n clocks" steps; a reference model works per step from the
// display rules and queues the pulses the DUT should emit, and a monitor pops
// and compares them whenever the DUT pulses an output.
module tb_seg_mux_decoder;

  localparam int SETTLE = 4;
  localparam int TMO    = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [15:0] time_bcd;
  logic        frame_valid;
  logic        seq_err;
  logic        dec_err;
  logic        stale;

  seg_mux_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .time_bcd    (time_bcd),
    .frame_valid (frame_valid),
    .seq_err     (seq_err),
    .dec_err     (dec_err),
    .stale       (stale)
  );

  always #100 clk = ~clk;

  typedef struct packed {
    logic        fv;
    logic        se;
    logic        de;
    logic [15:0] bcd;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_ev;
  ev_t exp_ev;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state
  logic [14:0] m_key;
  int          m_run;
  bit          m_capd;
  bit          m_in_frame;
  int          m_expect;
  logic [3:0]  m_dig [4];
  logic [15:0] m_bcd;
  int          m_idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_run = 0; m_capd = 0; m_in_frame = 0; m_expect = 0;
    for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
    m_bcd = 16'h0000; m_idle = 0;
  endtask

  // One settled digit seen at position p with glyph s.
  task automatic model_capture(input int p, input logic [6:0] s);
    ev_t e;
    logic [3:0] d;
    bit bad;
    bit publish;
    d = 4'hF; bad = 1; publish = 0;
    for (int k = 0; k < 10; k++)
      if (glyph[k] == s) begin d = 4'(k); bad = 0; end
    if (m_idle > TMO + 1) m_in_frame = 0;  // display went stale in between
    m_idle = 0;
    e = '{fv: 1'b0, se: 1'b0, de: bad, bcd: m_bcd};
    if (!m_in_frame) begin
      if (p == 0) begin m_dig[0] = d; m_in_frame = 1; m_expect = 1; end
    end else if (p == m_expect) begin
      m_dig[p] = d;
      if (p == 3) begin publish = 1; m_in_frame = 0; end
      else m_expect++;
    end else if (p == m_expect - 1) begin
      m_dig[p] = d;
    end else begin
      e.se = 1'b1;
      if (p == 0) begin m_dig[0] = d; m_expect = 1; end
      else m_in_frame = 0;
    end
    if (e.se || e.de) exp_q.push_back(e);
    if (publish) begin
      m_bcd = {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
      exp_q.push_back('{fv: 1'b1, se: 1'b0, de: 1'b0, bcd: m_bcd});
    end
  endtask

  // Hold an/seg for n sampling edges; the model decides whether and when it settles.
  task automatic step(input logic [7:0] a, input logic [7:0] s, input int n);
    logic [14:0] key;
    bit valid;
    int p;
    key   = {a, s[6:0]};
    valid = (a[7:4] == 4'hF) && ($countones(~a[3:0]) == 1);
    p = 0;
    for (int k = 0; k < 4; k++) if (!a[k]) p = k;
    if (key != m_key) begin m_key = key; m_run = 0; m_capd = 0; end
    for (int i = 0; i < n; i++) begin
      m_run++; m_idle++;
      if (valid && !m_capd && m_run >= SETTLE) begin
        m_capd = 1;
        model_capture(p, s[6:0]);
      end
    end
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3);
    step(8'hFE, {1'b1, glyph[d0]}, 20);
    step(8'hFD, {1'b1, glyph[d1]}, 20);
    step(8'hFB, {1'b1, glyph[d2]}, 20);
    step(8'hF7, {1'b1, glyph[d3]}, 20);
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && (frame_valid || seq_err || dec_err)) begin
      got_ev = '{fv: frame_valid, se: seq_err, de: dec_err, bcd: time_bcd};
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_event: got fv=%0b se=%0b de=%0b bcd=%h, required no pulse (t=%0t)",
                 got_ev.fv, got_ev.se, got_ev.de, got_ev.bcd, $time);
      end else begin
        exp_ev = exp_q.pop_front();
        check("event{fv,se,de,bcd}", 32'(got_ev), 32'(exp_ev));
      end
    end
  end

  int          r;
  int          pos;
  logic [3:0]  onehot;
  logic [7:0]  anw;
  logic [7:0]  bad_an [4] = '{8'hFC, 8'hEE, 8'h7E, 8'hF0};

  initial begin
    model_reset();
    reset = 1'b1;
    an    = 8'hFF;
    seg   = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_time_bcd", 32'(time_bcd), 32'h0);
    check("reset_frame_valid", 32'(frame_valid), 32'h0);
    check("reset_seq_err", 32'(seq_err), 32'h0);
    check("reset_dec_err", 32'(dec_err), 32'h0);
    check("reset_stale", 32'(stale), 32'h0);
    reset = 1'b0;

    // Clean scan 12:34
    scan(1, 2, 3, 4);
    check("scan_1234", 32'(time_bcd), 32'h1234);

    // Short glitch on digit 0 must not be captured
    step(8'hFE, 8'hF9, 8);
    step(8'hFE, 8'hFF, 3);
    step(8'hFE, 8'hF9, 9);
    step(8'hFD, 8'hA4, 20);
    step(8'hFB, 8'hB0, 20);
    step(8'hF7, 8'h99, 20);
    check("glitch_scan_1234", 32'(time_bcd), 32'h1234);

    // Skipped position -> seq_err, then a full frame 43:21
    step(8'hFE, 8'hF9, 20);
    step(8'hFB, 8'hB0, 20);
    step(8'hFD, 8'hA4, 20);
    step(8'hF7, 8'h99, 20);
    scan(4, 3, 2, 1);
    check("after_skip_4321", 32'(time_bcd), 32'h4321);

    // Blank glyph in digit 1 -> dec_err, frame carries F
    step(8'hFE, 8'hF9, 20);
    step(8'hFD, 8'h7F, 20);
    step(8'hFB, 8'hB0, 20);
    step(8'hF7, 8'h99, 20);
    check("dec_err_frame_1F34", 32'(time_bcd), 32'h1F34);

    // Timeout: blank display long enough to go stale, then recover
    step(8'hFF, 8'hFF, 1000);
    check("stale_low_early", 32'(stale), 32'h0);
    step(8'hFF, 8'hFF, 65000);
    check("stale_set", 32'(stale), 32'h1);
    step(8'hFE, {1'b1, glyph[5]}, 3);
    check("stale_held_before_capture", 32'(stale), 32'h1);
    step(8'hFE, {1'b1, glyph[5]}, 17);
    check("stale_cleared_by_capture", 32'(stale), 32'h0);
    step(8'hFD, {1'b1, glyph[6]}, 20);
    step(8'hFB, {1'b1, glyph[7]}, 20);
    step(8'hF7, {1'b1, glyph[8]}, 20);
    check("post_stale_5678", 32'(time_bcd), 32'h5678);

    // Reset in the middle of a frame
    step(8'hFE, {1'b1, glyph[9]}, 20);
    step(8'hFD, {1'b1, glyph[0]}, 20);
    step(8'hFB, {1'b1, glyph[1]}, 2);
    #5;
    reset = 1'b1;
    #1;
    check("midreset_time_bcd", 32'(time_bcd), 32'h0);
    check("midreset_frame_valid", 32'(frame_valid), 32'h0);
    check("midreset_seq_err", 32'(seq_err), 32'h0);
    check("midreset_dec_err", 32'(dec_err), 32'h0);
    check("midreset_stale", 32'(stale), 32'h0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    scan(9, 0, 1, 2);
    check("post_reset_9012", 32'(time_bcd), 32'h9012);

    // Randomised scan with glitches, blanks, jumps, bad glyphs, bad anode words
    pos = 0;
    for (int i = 0; i < 400; i++) begin
      onehot = 4'b0001 << pos;
      anw    = {4'hF, ~onehot};
      r      = $urandom_range(0, 99);
      if (r < 70) begin
        step(anw, {1'($urandom), glyph[$urandom_range(0, 9)]}, $urandom_range(5, 15));
        pos = (pos + 1) % 4;
      end else if (r < 78) begin
        step(anw, 8'($urandom), $urandom_range(1, 3));
      end else if (r < 85) begin
        step(8'hFF, 8'($urandom), $urandom_range(2, 10));
      end else if (r < 91) begin
        pos = $urandom_range(0, 3);
      end else if (r < 96) begin
        step(anw, {1'($urandom), 7'h7F}, $urandom_range(4, 8));
        pos = (pos + 1) % 4;
      end else begin
        step(bad_an[$urandom_range(0, 3)], {1'b1, glyph[$urandom_range(0, 9)]}, 6);
      end
    end
    step(8'hFF, 8'hFF, 20);
    check("all_expected_events_seen", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
